// File: rtl/match_overlay_ctrl.sv
// Frame-synchronous grey-out / message controller for the overlay stage.
// Tracks pause and end-of-match, drives blink phase and game freeze/reset.
module match_overlay_ctrl #(
  parameter logic [3:0]  WIN_SCORE       = 4'd15,
  parameter int unsigned BLINK_FRAMES    = 30,
  parameter int unsigned END_HOLD_FRAMES = 120
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic [3:0] score_left,
  input  logic [3:0] score_right,
  input  logic       pause_btn,
  input  logic       restart_btn,
  output logic       grey_en,
  output logic       endgame,
  output logic       msg_visible,
  output logic       winner,
  output logic       game_freeze,
  output logic       game_rst_req
);

  typedef enum logic [2:0] {
    ST_PLAY,
    ST_PAUSE,
    ST_END_HOLD,
    ST_END_WAIT,
    ST_RESTART
  } state_t;

  localparam logic [7:0] BLINK_LAST =
    8'(BLINK_FRAMES - 1);
  localparam logic [7:0] HOLD_LAST =
    8'(END_HOLD_FRAMES - 1);

  state_t     state_q, state_d;
  logic [7:0] blink_q, blink_d;
  logic [7:0] hold_q, hold_d;
  logic       vis_q, vis_d;
  logic       win_q, win_d;

  logic       vsync_q;
  logic       pause_q;
  logic       restart_q;

  logic       grey_q, grey_d;
  logic       endg_q, endg_d;
  logic       msg_q, msg_d;
  logic       wnr_q, wnr_d;
  logic       frz_q, frz_d;
  logic       req_q, req_d;

  logic       frame_tick;
  logic       pause_rise;
  logic       restart_rise;
  logic       left_win;
  logic       right_win;
  logic       win;
  logic       in_msg;
  logic       in_end;

  assign frame_tick   = vsync_in & ~vsync_q;
  assign pause_rise   = pause_btn & ~pause_q;
  assign restart_rise = restart_btn & ~restart_q;

  assign left_win  = score_left >= WIN_SCORE;
  assign right_win = score_right >= WIN_SCORE;
  assign win       = left_win | right_win;

  assign in_end = (state_q == ST_END_HOLD)
                | (state_q == ST_END_WAIT);
  assign in_msg = in_end | (state_q == ST_PAUSE);

  always_ff @(posedge pclk) begin
    if (rst) begin
      vsync_q   <= 1'b0;
      pause_q   <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      vsync_q   <= vsync_in;
      pause_q   <= pause_btn;
      restart_q <= restart_btn;
    end
  end

  always_comb begin
    state_d = state_q;
    blink_d = blink_q;
    hold_d  = hold_q;
    vis_d   = vis_q;
    win_d   = win_q;

    // Blink runs in every message state; entries below override it.
    if (in_msg && frame_tick) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = 8'd0;
        vis_d   = ~vis_q;
      end else begin
        blink_d = blink_q + 8'd1;
      end
    end

    unique case (state_q)
      ST_PLAY: begin
        if (win) begin
          state_d = ST_END_HOLD;
          win_d   = ~left_win;
          blink_d = 8'd0;
          vis_d   = 1'b1;
          hold_d  = 8'd0;
        end else if (pause_rise) begin
          state_d = ST_PAUSE;
          blink_d = 8'd0;
          vis_d   = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (restart_rise) begin
          state_d = ST_RESTART;
        end else if (pause_rise) begin
          state_d = ST_PLAY;
        end
      end
      ST_END_HOLD: begin
        if (frame_tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_END_WAIT;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      ST_END_WAIT: begin
        if (restart_rise) begin
          state_d = ST_RESTART;
        end
      end
      ST_RESTART: begin
        state_d = ST_PLAY;
        win_d   = 1'b0;
      end
      default: begin
        state_d = ST_PLAY;
      end
    endcase
  end

  always_comb begin
    grey_d = in_msg;
    endg_d = in_end;
    msg_d  = in_msg & vis_q;
    wnr_d  = in_end & win_q;
    frz_d  = state_q != ST_PLAY;
    req_d  = state_q == ST_RESTART;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= ST_PLAY;
      blink_q <= 8'd0;
      hold_q  <= 8'd0;
      vis_q   <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;
      hold_q  <= hold_d;
      vis_q   <= vis_d;
      win_q   <= win_d;
    end
  end

  // Outputs lag the state register by one cycle.
  always_ff @(posedge pclk) begin
    if (rst) begin
      grey_q <= 1'b0;
      endg_q <= 1'b0;
      msg_q  <= 1'b0;
      wnr_q  <= 1'b0;
      frz_q  <= 1'b0;
      req_q  <= 1'b0;
    end else begin
      grey_q <= grey_d;
      endg_q <= endg_d;
      msg_q  <= msg_d;
      wnr_q  <= wnr_d;
      frz_q  <= frz_d;
      req_q  <= req_d;
    end
  end

  assign grey_en      = grey_q;
  assign endgame      = endg_q;
  assign msg_visible  = msg_q;
  assign winner       = wnr_q;
  assign game_freeze  = frz_q;
  assign game_rst_req = req_q;

endmodule

// File: tb/tb_match_overlay_ctrl.sv
// Bench for match_overlay_ctrl: directed scenarios plus random traffic,
// checked against a tick-counting behavioural model.
module tb_match_overlay_ctrl;

  localparam int BF = 30;
  localparam int HF = 120;

  localparam int M_PLAY = 0;
  localparam int M_PAUSE = 1;
  localparam int M_HOLD = 2;
  localparam int M_WAIT = 3;
  localparam int M_RSTRT = 4;

  logic       pclk = 1'b0;
  logic       rst;
  logic       vsync_in;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       pause_btn;
  logic       restart_btn;
  logic       grey_en;
  logic       endgame;
  logic       msg_visible;
  logic       winner;
  logic       game_freeze;
  logic       game_rst_req;

  match_overlay_ctrl dut (
    .pclk        (pclk),
    .rst         (rst),
    .vsync_in    (vsync_in),
    .score_left  (score_left),
    .score_right (score_right),
    .pause_btn   (pause_btn),
    .restart_btn (restart_btn),
    .grey_en     (grey_en),
    .endgame     (endgame),
    .msg_visible (msg_visible),
    .winner      (winner),
    .game_freeze (game_freeze),
    .game_rst_req(game_rst_req)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int passes = 0;

  // Model: state name, ticks seen since message entry, ticks in hold.
  int   m_st = M_PLAY;
  int   blink_n = 0;
  int   hold_n = 0;
  bit   m_win = 0;
  bit   pv = 0, pp = 0, pr = 0;
  logic [5:0] exp_v = '0;

  logic [5:0] dut_v;
  assign dut_v = {grey_en, endgame, msg_visible,
                  winner, game_freeze, game_rst_req};

  always @(posedge pclk) begin
    bit tick, prise, rrise, inmsg, isend, vis, w;
    if (rst) begin
      m_st = M_PLAY; exp_v = '0;
      pv = 0; pp = 0; pr = 0;
      blink_n = 0; hold_n = 0; m_win = 0;
    end else begin
      isend = (m_st == M_HOLD) || (m_st == M_WAIT);
      inmsg = isend || (m_st == M_PAUSE);
      vis   = ((blink_n / BF) % 2) == 0;
      exp_v = {inmsg, isend, inmsg && vis,
               isend && m_win, m_st != M_PLAY,
               m_st == M_RSTRT};
      tick  = vsync_in && !pv;
      prise = pause_btn && !pp;
      rrise = restart_btn && !pr;
      pv = vsync_in; pp = pause_btn; pr = restart_btn;
      w = (score_left >= 15) || (score_right >= 15);
      case (m_st)
        M_PLAY:
          if (w) begin
            m_st = M_HOLD;
            m_win = !(score_left >= 15);
            blink_n = 0; hold_n = 0;
          end else if (prise) begin
            m_st = M_PAUSE; blink_n = 0;
          end
        M_PAUSE:
          if (rrise) m_st = M_RSTRT;
          else if (prise) m_st = M_PLAY;
          else if (tick) blink_n++;
        M_HOLD:
          if (tick) begin
            blink_n++; hold_n++;
            if (hold_n == HF) m_st = M_WAIT;
          end
        M_WAIT:
          if (rrise) m_st = M_RSTRT;
          else if (tick) blink_n++;
        default: m_st = M_PLAY;
      endcase
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vsync_in = 1'($urandom);
      pause_btn = 1'($urandom);
      restart_btn = 1'($urandom);
      score_left = 4'($urandom);
      score_right = 4'($urandom);
      step();
      checks++;
      if (dut_v !== 6'b0) begin
        $display("FAIL reset_out got=%b want=000000", dut_v);
      end else passes++;
    end
    vsync_in = 0; pause_btn = 0; restart_btn = 0;
    score_left = 0; score_right = 0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dut_v !== exp_v || dut_v !== 6'b0) begin
        $display("FAIL reset_idle got=%b want=%b", dut_v, exp_v);
      end else passes++;
    end
  endtask

  task automatic test_pause();
    pause_btn = 1'b1;
    step();
    checks++;
    if (grey_en !== 1'b0) begin
      $display("FAIL pause_latency1 got=%b want=0", grey_en);
    end else passes++;
    step();
    checks++;
    if (dut_v !== 6'b101010 || dut_v !== exp_v) begin
      $display("FAIL pause_enter got=%b want=101010", dut_v);
    end else passes++;
    pause_btn = 1'b0;
    for (int t = 1; t <= 2 * BF; t++) begin
      vsync_in = 1'b1;
      step();
      checks++;
      if (dut_v !== exp_v) begin
        $display("FAIL pause_blink t=%0d got=%b want=%b",
                 t, dut_v, exp_v);
      end else passes++;
      vsync_in = 1'b0;
      step();
      checks++;
      if (dut_v !== exp_v) begin
        $display("FAIL pause_blink t=%0d got=%b want=%b",
                 t, dut_v, exp_v);
      end else passes++;
      if (t == BF || t == 2 * BF) begin
        checks++;
        if (msg_visible !== (t == 2 * BF)) begin
          $display("FAIL blink_phase t=%0d got=%b want=%b",
                   t, msg_visible, t == 2 * BF);
        end else passes++;
      end
    end
    pause_btn = 1'b1;
    step();
    step();
    checks++;
    if (dut_v !== 6'b0 || dut_v !== exp_v) begin
      $display("FAIL pause_exit got=%b want=000000", dut_v);
    end else passes++;
    pause_btn = 1'b0;
    step();
  endtask

  task automatic test_win_pause();
    score_right = 4'd15;
    pause_btn = 1'b1;
    step();
    step();
    checks++;
    if (dut_v !== 6'b111110 || dut_v !== exp_v) begin
      $display("FAIL win_right got=%b want=111110", dut_v);
    end else passes++;
    pause_btn = 1'b0;
    step();
  endtask

  task automatic test_hold();
    for (int t = 1; t <= HF; t++) begin
      restart_btn = (t % 17 == 3);
      pause_btn = (t % 23 == 5);
      vsync_in = 1'b1;
      step();
      restart_btn = 1'b0;
      pause_btn = 1'b0;
      vsync_in = 1'b0;
      step();
      checks++;
      if (dut_v !== exp_v || !endgame || game_rst_req) begin
        $display("FAIL hold t=%0d got=%b want=%b",
                 t, dut_v, exp_v);
      end else passes++;
    end
    score_right = 4'd0;
    restart_btn = 1'b1;
    step();
    step();
    checks++;
    if (dut_v !== 6'b000011 || dut_v !== exp_v) begin
      $display("FAIL restart_pulse got=%b want=000011", dut_v);
    end else passes++;
    step();
    checks++;
    if (dut_v !== 6'b0 || dut_v !== exp_v) begin
      $display("FAIL restart_play got=%b want=000000", dut_v);
    end else passes++;
    restart_btn = 1'b0;
    step();
  endtask

  task automatic test_tie_and_rst();
    score_left = 4'd15;
    score_right = 4'd15;
    step();
    step();
    checks++;
    if (dut_v !== 6'b111010 || dut_v !== exp_v) begin
      $display("FAIL tie_winner got=%b want=111010", dut_v);
    end else passes++;
    for (int t = 0; t < HF + 3; t++) begin
      vsync_in = 1'b1;
      step();
      vsync_in = 1'b0;
      step();
    end
    checks++;
    if (!endgame || dut_v !== exp_v || m_st != M_WAIT) begin
      $display("FAIL tie_wait got=%b want=%b", dut_v, exp_v);
    end else passes++;
    score_left = 0;
    score_right = 0;
    rst = 1'b1;
    step();
    checks++;
    if (dut_v !== 6'b0) begin
      $display("FAIL rst_wait got=%b want=000000", dut_v);
    end else passes++;
    rst = 1'b0;
    step();
    pause_btn = 1'b1;
    step();
    pause_btn = 1'b0;
    step();
    restart_btn = 1'b1;
    step();
    rst = 1'b1;
    restart_btn = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dut_v !== 6'b0 || dut_v !== exp_v) begin
        $display("FAIL rst_restart i=%0d got=%b want=000000",
                 i, dut_v);
      end else passes++;
      step();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 6000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) vsync_in = ~vsync_in;
      if ($urandom_range(0, 29) == 0) pause_btn = ~pause_btn;
      if ($urandom_range(0, 39) == 0)
        restart_btn = ~restart_btn;
      if ($urandom_range(0, 49) == 0) begin
        score_left = 4'($urandom_range(0, 14));
        score_right = 4'($urandom_range(0, 14));
        if ($urandom_range(0, 5) == 0) score_left = 4'd15;
        if ($urandom_range(0, 5) == 0) score_right = 4'd15;
      end
      step();
      checks++;
      if (dut_v !== exp_v) begin
        $display("FAIL random c=%0d got=%b want=%b",
                 c, dut_v, exp_v);
      end else passes++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    vsync_in = 0; pause_btn = 0; restart_btn = 0;
    score_left = 0; score_right = 0;
    test_reset();
    test_pause();
    test_win_pause();
    test_hold();
    test_tie_and_rst();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/match_overlay_ctrl.md
Name: match_overlay_ctrl

Overview:
- Frame-synchronous controller for the grey-out/text overlay stage.
- Decides when the screen is greyed out, whether the pause or end-game message is selected, and the message blink phase.
- Freezes game logic and requests a game reset on restart.
- Sits between the score/button logic and the overlay stage, clocked by pclk.

Parameters:
- WIN_SCORE, 15: score value (4-bit) that ends the match.
- BLINK_FRAMES, 30: frame ticks per blink half-period, 1..255.
- END_HOLD_FRAMES, 120: frame ticks restart is locked out after a win, 1..255.

Ports:
- pclk  input  1  pixel clock.
- rst  input  1  synchronous reset, active-high.
- vsync_in  input  1  vertical sync from timing chain (active-high).
- score_left  input  4  left player score.
- score_right  input  4  right player score.
- pause_btn  input  1  pause button, already synchronised/debounced, level.
- restart_btn  input  1  restart button, already synchronised/debounced, level.
- grey_en  output  1  overlay stage greys image and draws text.
- endgame  output  1  1 = end-game message bank, 0 = pause message bank.
- msg_visible  output  1  text drawn when 1 (blink phase).
- winner  output  1  0 = left won, 1 = right won; valid while endgame=1.
- game_freeze  output  1  game physics/score must hold.
- game_rst_req  output  1  single-cycle pulse: reset scores/positions.

Behaviour:
- All outputs registered. On rst: state=PLAY, all outputs 0, internal counters 0, edge-detect registers 0.
- frame_tick = vsync_in & ~vsync_d. vsync_d is a register.
- pause_rise and restart_rise are derived the same way from their previous-value registers.
- win = (score_left >= WIN_SCORE) | (score_right >= WIN_SCORE).
- winner is latched on entry to END_HOLD. Left has priority if both scores reach WIN_SCORE in the same cycle.
- PLAY: grey_en=0, endgame=0, game_freeze=0, msg_visible=0.
  - win -> END_HOLD.
  - else pause_rise -> PAUSE. win has priority over a simultaneous pause_rise.
  - restart_rise ignored.
- PAUSE: grey_en=1, endgame=0, game_freeze=1.
  - restart_rise -> RESTART. restart has priority over a simultaneous pause_rise.
  - else pause_rise -> PLAY.
  - win is not evaluated (scores frozen).
- END_HOLD: grey_en=1, endgame=1, game_freeze=1.
  - hold_cnt increments on frame_tick. When hold_cnt reaches END_HOLD_FRAMES-1 on a frame_tick -> END_WAIT.
  - restart_rise and pause_rise ignored.
- END_WAIT: outputs as END_HOLD. restart_rise -> RESTART; pause_rise ignored.
- RESTART: one cycle.
  - game_rst_req=1, game_freeze=1, grey_en=0, endgame=0, winner cleared to 0.
  - Next state PLAY unconditionally; game_rst_req returns to 0 next cycle.
- Blink:
  - On every entry to PAUSE or END_HOLD: msg_visible=1, blink_cnt=0.
  - In PAUSE/END_HOLD/END_WAIT, blink_cnt increments on frame_tick. At BLINK_FRAMES-1 it wraps to 0 and msg_visible toggles.
  - The END_HOLD -> END_WAIT transition does not reset blink phase.
- Counters are 8-bit and saturate-free: they are compared with ==, so parameters must be within 1..255.
- hold_cnt is cleared on entry to END_HOLD.
- Output timing: each output changes in the cycle after the state register updates, i.e. 1 pclk after the triggering input edge is registered. Total latency from button edge to output = 2 pclk.
- Button held high across states produces only one rise; no auto-repeat.
- rst asserted in any state returns to PLAY with all outputs 0 on the next edge. A pending game_rst_req pulse is dropped.

Test Plan:
- Reset, then pulse pause_btn -> grey_en=1, endgame=0, game_freeze=1, msg_visible=1 two cycles after the rise. Second pause_btn rise -> all 0.
- In PAUSE, 60 vsync pulses -> msg_visible toggles after tick 30 and tick 60 (back to 1).
- In PLAY, score_right=15 with pause_btn rising the same cycle -> END_HOLD, winner=1, endgame=1; pause ignored.
- END_HOLD with restart_btn pulsed before 120 frame ticks -> no change. After 120 ticks, restart rise -> single-cycle game_rst_req=1, then PLAY with all outputs 0.
- score_left=15 and score_right=15 simultaneously -> winner=0.
- rst asserted mid-END_WAIT and mid-RESTART -> next cycle all outputs 0, state PLAY, no game_rst_req.
